csa_seq_multiplier: RTL and testbench

- Iterative unsigned WIDTH x WIDTH multiplier for the multiplier datapath.
- Each cycle, it reduces one shifted partial product into a redundant sum/carry accumulator using bitwise 3:2 carry-save compression.
- After all partial products are absorbed, it performs one carry-propagate add and presents the 2*WIDTH-bit product on a valid/ready output.
- It sits between operand producers and result consumers, acting as the sequential consumer of carry-save adder stages.

---
 rtl/csa_seq_multiplier.sv | 96 +++++++++
 tb/tb_csa_seq_multiplier.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_seq_multiplier.sv
// Iterative unsigned WIDTH x WIDTH multiplier: one partial product per cycle is folded into a
// carry-save sum/carry pair, then a single carry-propagate add yields the 2*WIDTH-bit product.
module csa_seq_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      st_idle,
      st_accum,
      st_resolve,
      st_done
   } state_e;

   state_e          state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [PW-1:0]    s_q, c_q, pp, maj, product_q;
   logic [CW-1:0]    cnt_q;
   logic             last;

   assign pp   = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
   assign maj  = (s_q & c_q) | (s_q & pp) | (c_q & pp);
   assign last = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= st_idle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         st_idle:    if (in_valid) state_d = st_accum;
         st_accum:   if (last) state_d = st_resolve;
         st_resolve: state_d = st_done;
         st_done:    if (out_ready) state_d = st_idle;
         default:    state_d = st_idle;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == st_idle);
      busy      = (state_q == st_accum) || (state_q == st_resolve);
      out_valid = (state_q == st_done);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         s_q       <= '0;
         c_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         unique case (state_q)
            st_idle: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  s_q   <= '0;
                  c_q   <= '0;
                  cnt_q <= '0;
               end
            end
            st_accum: begin
               s_q   <= s_q ^ c_q ^ pp;
               // Top bit of maj is always zero here, so the shift loses nothing.
               c_q   <= maj << 1;
               cnt_q <= last ? '0 : cnt_q + 1'b1;
            end
            st_resolve: product_q <= s_q + c_q;
            default: ;
         endcase
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Scoreboarded bench for csa_seq_multiplier: directed cases at WIDTH=8, randomized traffic with
// output stalls at WIDTH=8 and WIDTH=5, each checked against plain a*b.
module tb_csa_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [7:0]  a, b;
   logic [15:0] product;

   logic        rst5, in_valid5, in_ready5, out_valid5, out_ready5, busy5;
   logic [4:0]  a5, b5;
   logic [9:0]  product5;

   int tests = 0;
   int fails = 0;
   bit rnd   = 1'b0;
   bit done5 = 1'b0;

   logic [15:0] q8[$];
   logic [9:0]  q5[$];
   logic        pv8 = 1'b0, ph8 = 1'b0, pv5 = 1'b0, ph5 = 1'b0;
   logic [15:0] pp8 = '0;
   logic [9:0]  pp5 = '0;

   always #5 clk = ~clk;

   csa_seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
   );

   csa_seq_multiplier #(.WIDTH(5)) dut5 (
      .clk(clk), .rst(rst5), .in_valid(in_valid5), .in_ready(in_ready5), .a(a5), .b(b5),
      .out_valid(out_valid5), .out_ready(out_ready5), .product(product5), .busy(busy5)
   );

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Expected products are queued at acceptance and retired at each output handshake.
   always @(negedge clk) begin
      if (rst) begin
         q8.delete();
         pv8 <= 1'b0;
         ph8 <= 1'b0;
      end else begin
         if (pv8 && !ph8) begin
            check("w8_hold_valid", out_valid, 1);
            check("w8_hold_product", product, pp8);
         end
         if (in_valid && in_ready) q8.push_back(16'(a) * 16'(b));
         if (out_valid && out_ready) begin
            if (q8.size() == 0) fail_now("w8_unexpected_output");
            else check("w8_product", product, q8.pop_front());
         end
         pv8 <= out_valid;
         ph8 <= out_valid && out_ready;
         pp8 <= product;
      end
   end

   always @(negedge clk) begin
      if (rst5) begin
         q5.delete();
         pv5 <= 1'b0;
         ph5 <= 1'b0;
      end else begin
         if (pv5 && !ph5) begin
            check("w5_hold_valid", out_valid5, 1);
            check("w5_hold_product", product5, pp5);
         end
         if (in_valid5 && in_ready5) q5.push_back(10'(a5) * 10'(b5));
         if (out_valid5 && out_ready5) begin
            if (q5.size() == 0) fail_now("w5_unexpected_output");
            else check("w5_product", product5, q5.pop_front());
         end
         pv5 <= out_valid5;
         ph5 <= out_valid5 && out_ready5;
         pp5 <= product5;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Returns just after the accepting edge (first ACCUM cycle).
   task automatic accept(input logic [7:0] x, input logic [7:0] y);
      int n = 0;
      a = x;
      b = y;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         step();
         n++;
      end
      if (!in_ready) fail_now("accept_timeout");
      step();
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
   endtask

   task automatic wait_out(output int lat, output int bcnt, output int rdy);
      lat  = 0;
      bcnt = 0;
      rdy  = 0;
      while (!out_valid && lat < 50) begin
         if (busy) bcnt++;
         if (in_ready) rdy++;
         step();
         lat++;
      end
      if (!out_valid) fail_now("out_valid_timeout");
   endtask

   task automatic run_dir(input logic [7:0] x, input logic [7:0] y, input int exp);
      int lat, bcnt, rdy;
      out_ready = 1'b1;
      accept(x, y);
      wait_out(lat, bcnt, rdy);
      check("latency", lat, 9);
      check("busy_cycles", bcnt, 9);
      check("in_ready_while_busy", rdy, 0);
      check("dir_product", product, exp);
      step();
      check("valid_after_handshake", out_valid, 0);
      check("ready_after_handshake", in_ready, 1);
   endtask

   initial begin
      int lat, bcnt, rdy, n;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      step();
      step();
      rst = 1'b0;
      check("reset_out_valid", out_valid, 0);
      check("reset_product", product, 0);
      check("reset_busy", busy, 0);
      check("reset_in_ready", in_ready, 1);

      run_dir(8'd13, 8'd11, 143);
      run_dir(8'd255, 8'd255, 65025);
      run_dir(8'd0, 8'd200, 0);
      run_dir(8'd1, 8'd128, 128);

      // Backpressure: result parked in DONE while new operands are offered.
      out_ready = 1'b0;
      accept(8'd6, 8'd7);
      wait_out(lat, bcnt, rdy);
      check("bp_latency", lat, 9);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         a = 8'd2;
         b = 8'd2;
         check("bp_valid", out_valid, 1);
         check("bp_product", product, 42);
         check("bp_in_ready", in_ready, 0);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_release_valid", out_valid, 0);
      check("bp_release_ready", in_ready, 1);

      // Reset during the 4th ACCUM cycle, with a competing in_valid.
      accept(8'd100, 8'd3);
      step();
      step();
      step();
      rst = 1'b1;
      in_valid = 1'b1;
      a = 8'd7;
      b = 8'd7;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_product", product, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_busy", busy, 0);
      run_dir(8'd5, 8'd5, 25);

      // Back-to-back: in_valid held high across the first output handshake.
      out_ready = 1'b1;
      a = 8'd3;
      b = 8'd4;
      in_valid = 1'b1;
      step();
      a = 8'd9;
      b = 8'd9;
      wait_out(lat, bcnt, rdy);
      check("b2b_first_latency", lat, 9);
      check("b2b_first_product", product, 12);
      step();
      check("b2b_idle_ready", in_ready, 1);
      check("b2b_idle_busy", busy, 0);
      step();
      check("b2b_second_accepted", busy, 1);
      in_valid = 1'b0;
      wait_out(lat, bcnt, rdy);
      check("b2b_second_latency", lat, 9);
      check("b2b_second_product", product, 81);
      step();

      rnd = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) step();
         accept(8'($urandom), 8'($urandom));
      end
      n = 0;
      while (q8.size() != 0 && n < 2000) begin
         step();
         n++;
      end
      rnd = 1'b0;
      n = 0;
      while (!done5 && n < 40000) begin
         step();
         n++;
      end
      if (!done5) fail_now("w5_run_timeout");
      check("w8_queue_drained", q8.size(), 0);
      check("w5_queue_drained", q5.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   task automatic step5();
      @(posedge clk);
      #1;
      out_ready5 = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      int n;
      rst5 = 1'b1;
      in_valid5 = 1'b0;
      out_ready5 = 1'b0;
      a5 = '0;
      b5 = '0;
      step5();
      step5();
      rst5 = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) step5();
         a5 = 5'($urandom);
         b5 = 5'($urandom);
         in_valid5 = 1'b1;
         n = 0;
         while (!in_ready5 && n < 200) begin
            step5();
            n++;
         end
         if (!in_ready5) fail_now("w5_accept_timeout");
         step5();
         in_valid5 = 1'b0;
         a5 = 5'($urandom);
         b5 = 5'($urandom);
      end
      n = 0;
      while (q5.size() != 0 && n < 2000) begin
         step5();
         n++;
      end
      done5 = 1'b1;
   end

endmodule
